// File: rtl/repetition_serial_encoder.sv
// Repetition encoder: holds one accepted word and streams REPETITION
// identical copies downstream with a valid/ready handshake on both sides.
module repetition_serial_encoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int REPETITION  = 3,
    localparam int INDEX_WIDTH = (REPETITION > 1) ? $clog2(REPETITION) : 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [DATA_WIDTH-1:0]  data,
    output logic                   copy_valid,
    input  logic                   copy_ready,
    output logic [DATA_WIDTH-1:0]  copy_data,
    output logic [INDEX_WIDTH-1:0] copy_index,
    output logic                   copy_last,
    output logic                   busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(REPETITION - 1);

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;

    logic send;
    logic last;
    logic copy_hs;
    logic data_hs;

    assign send    = (state_q == SEND);
    assign last    = send && (idx_q == LAST_IDX);
    assign copy_hs = send && copy_ready;
    assign data_hs = data_valid && data_ready;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (data_hs) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (copy_hs && last && !data_hs) begin
                    state_d = IDLE;
                end
            end
        endcase
        // A new word always restarts the index, even on the final copy's edge
        if (data_hs) begin
            hold_d = data;
            idx_d  = '0;
        end else if (copy_hs) begin
            idx_d = last ? '0 : idx_q + INDEX_WIDTH'(1);
        end
    end

    always_comb begin
        busy       = send;
        copy_valid = send;
        copy_data  = hold_q;
        copy_index = idx_q;
        copy_last  = last;
        data_ready = !send || (copy_hs && last);
    end

endmodule

// File: doc/repetition_serial_encoder.md
REPETITION_SERIAL_ENCODER -- requirements
Module: repetition_serial_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one data word and of one output copy.
REQ-002 SHALL have parameter REPETITION, default 3: number of copies emitted per accepted word; legal range >= 1.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port data_valid  input  1  upstream word valid.
REQ-006 SHALL have port data_ready  output  1  encoder can accept a word this cycle.
REQ-007 SHALL have port data  input  DATA_WIDTH  word to encode.
REQ-008 SHALL have port copy_valid  output  1  a copy is presented downstream.
REQ-009 SHALL have port copy_ready  input  1  downstream accepts the presented copy.
REQ-010 SHALL have port copy_data  output  DATA_WIDTH  current copy, bit-identical to the held word.
REQ-011 SHALL have port copy_index  output  INDEX_WIDTH  copy number 0..REPETITION-1; INDEX_WIDTH = max(1, clog2(REPETITION)).
REQ-012 SHALL have port copy_last  output  1  high when copy_index == REPETITION-1 and copy_valid is high.
REQ-013 SHALL have port busy  output  1  a word is held and not all copies have been accepted.

Function
REQ-014 SHALL use two states: IDLE (no held word) and SEND (word held, copies pending); busy = (state == SEND).
REQ-015 SHALL accept a word on data handshake = data_valid & data_ready at a rising edge, latching data into the hold register.
REQ-016 SHALL drive data_ready = ~busy | (copy_valid & copy_ready & copy_last); this combinational path from copy_ready is intentional.
REQ-017 SHALL, on word acceptance, enter SEND with copy_index = 0; copy_valid rises the cycle after acceptance (latency 1 cycle, no combinational data-to-copy_data path).
REQ-018 SHALL drive copy_valid = busy; copy_data = hold register throughout SEND.
REQ-019 SHALL keep copy_data, copy_index and copy_last stable while copy_valid & ~copy_ready; copy_valid SHALL not drop without a copy handshake.
REQ-020 SHALL increment copy_index by 1 on each copy handshake (copy_valid & copy_ready) where copy_last is low.
REQ-021 SHALL, on a copy handshake with copy_last high and no data handshake in the same cycle, return to IDLE with copy_index = 0.
REQ-022 SHALL, on a copy handshake with copy_last high and a simultaneous data handshake, load the new word, set copy_index = 0 and remain in SEND (back-to-back words, no bubble).
REQ-023 SHALL ignore data_valid and leave data unsampled whenever data_ready is low.
REQ-024 SHALL, for REPETITION = 1, hold copy_index at 0 with copy_last high on every valid copy.
REQ-025 SHALL emit exactly REPETITION copies per accepted word, in index order, never skipping or repeating an index.
REQ-026 SHALL guarantee that the concatenation of the REPETITION copies, copy k at bits [k*DATA_WIDTH +: DATA_WIDTH], forms a block that the team's majority-vote corrector decodes to the original word with its error flag low.

Reset
REQ-027 SHALL, while resetn is low at a rising edge, set state IDLE, copy_valid 0, busy 0, copy_index 0, copy_last 0, hold register 0.
REQ-028 SHALL, on reset asserted mid-SEND, discard the held word and all pending copies; no further copies of it appear after reset release.
REQ-029 SHALL present data_ready = 1 in the first cycle after resetn returns high.

Verification
REQ-030 SHALL cover single word: DATA_WIDTH=8, REPETITION=3, data=0xA5 accepted, copy_ready held 1 -> copies 0xA5 with index 0,1,2 on three consecutive cycles, copy_last on index 2, busy low next cycle.
REQ-031 SHALL cover backpressure: copy_ready low 4 cycles during index 1 of word 0x3C -> copy_data 0x3C, index 1 stable all 4 cycles, data_ready low throughout.
REQ-032 SHALL cover back-to-back: word 0x11 then 0x22 offered continuously with copy_ready 1 -> 6 consecutive copies 0x11,0x11,0x11,0x22,0x22,0x22, no bubble, data_ready high on cycle of 0x11 index 2.
REQ-033 SHALL cover reset mid-operation: resetn low for one edge after index 0 of 0xFF accepted -> copy_valid 0, index 0 next cycle, no 0xFF copies thereafter.
REQ-034 SHALL cover REPETITION=1: words 0x01,0x02 streamed -> one copy each, copy_last high on both, index 0.
REQ-035 SHALL cover round trip: random words through encoder, copies concatenated and fed to the majority-vote corrector with one copy bit-flipped -> corrected data equals original, error flag high.
